// File: rtl/packer_ts_pkg.sv
// Shared helpers for the timestamped sample packer: lane geometry and
// channel-mask arithmetic used by the compactor and the top level.
package packer_ts_pkg;

  localparam int MAX_CHANS = 64;

  function automatic int calc_lanes(input int out_w, input int sample_w);
    return out_w / sample_w;
  endfunction

  // One extra bit so fill can be compared against LANES without wrapping
  function automatic int calc_fill_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  function automatic int popcount(input logic [MAX_CHANS-1:0] mask);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CHANS; i++) cnt += int'(mask[i]);
    return cnt;
  endfunction

  // Channel index feeding output lane 'lane', or -1 when fewer channels are enabled
  function automatic int lane_sel(input logic [MAX_CHANS-1:0] mask, input int lane);
    int cnt;
    int sel;
    cnt = 0;
    sel = -1;
    for (int i = 0; i < MAX_CHANS; i++) begin
      if (mask[i]) begin
        if (cnt == lane && sel < 0) sel = i;
        cnt++;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/packer_ts_n_sample_compactor.sv
// Combinational compaction of the enabled channels into consecutive lanes,
// lowest enabled channel in lane 0; unused lanes are driven to zero.
module sample_compactor import packer_ts_pkg::*; #(
  parameter int NUM_CHANS = 4,
  parameter int SAMPLE_W  = 16,
  parameter int LANES     = 4,
  parameter int FILL_W    = 3
) (
  input  logic [NUM_CHANS-1:0]          i_mask,
  input  logic [NUM_CHANS*SAMPLE_W-1:0] i_data,
  output logic [LANES*SAMPLE_W-1:0]     o_compacted,
  output logic [FILL_W-1:0]             o_k
);

  logic [MAX_CHANS-1:0] w_mask_ext;

  assign w_mask_ext = MAX_CHANS'(i_mask);
  assign o_k        = FILL_W'(popcount(w_mask_ext));

  always_comb begin
    o_compacted = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < NUM_CHANS; c++) begin
        if (lane_sel(w_mask_ext, l) == c)
          o_compacted[l*SAMPLE_W +: SAMPLE_W] = i_data[c*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

endmodule

// File: rtl/packer_ts_n.sv
// Packs masked channel samples into OUT_W words tagged with the lane-0 timestamp,
// with a one-deep output register, sticky overflow and a first-word sync flag.
module packer_ts_n import packer_ts_pkg::*; #(
  parameter int NUM_CHANS = 4,
  parameter int SAMPLE_W  = 16,
  parameter int OUT_W     = 64,
  parameter int TS_W      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TS_W-1:0]               timestamp_in,
  input  logic [NUM_CHANS-1:0]          chan_mask,
  input  logic                          en,
  input  logic [NUM_CHANS*SAMPLE_W-1:0] data_in,
  input  logic                          data_out_ready,
  output logic                          data_out_valid,
  output logic [OUT_W-1:0]              data_out,
  output logic                          data_out_sync,
  output logic [TS_W-1:0]               timestamp_out,
  output logic                          overflow
);

  localparam int LANES  = calc_lanes(OUT_W, SAMPLE_W);
  localparam int FILL_W = calc_fill_w(LANES);
  localparam int LW     = LANES * SAMPLE_W;

  logic [LW-1:0]        w_compacted;
  logic [FILL_W-1:0]    w_k;
  logic [FILL_W:0]      w_sum;
  logic [2*LW-1:0]      w_shift;
  logic [2*LW-1:0]      w_merged;
  logic [TS_W-1:0]      w_word_ts;
  logic                 w_mask_chg;
  logic                 w_accept;
  logic                 w_complete;
  logic                 w_spill;
  logic                 w_out_free;

  logic [NUM_CHANS-1:0] r_mask_q;
  logic [FILL_W-1:0]    r_fill;
  logic [2*LW-1:0]      r_stage;
  logic [TS_W-1:0]      r_ts_part;
  logic                 r_sync_pend;
  logic                 r_valid;
  logic [OUT_W-1:0]     r_data;
  logic [TS_W-1:0]      r_ts;
  logic                 r_sync;
  logic                 r_ovf;

  sample_compactor #(
    .NUM_CHANS (NUM_CHANS),
    .SAMPLE_W  (SAMPLE_W),
    .LANES     (LANES),
    .FILL_W    (FILL_W)
  ) u_compactor (
    .i_mask      (r_mask_q),
    .i_data      (data_in),
    .o_compacted (w_compacted),
    .o_k         (w_k)
  );

  assign w_mask_chg = (chan_mask != r_mask_q);
  assign w_accept   = en && !w_mask_chg && (r_mask_q != '0);
  assign w_sum      = {1'b0, r_fill} + {1'b0, w_k};
  assign w_complete = w_accept && (w_sum >= (FILL_W+1)'(LANES));
  assign w_spill    = (w_sum > (FILL_W+1)'(LANES));
  assign w_out_free = !r_valid || data_out_ready;
  assign w_word_ts  = (r_fill == '0) ? timestamp_in : r_ts_part;
  assign w_shift    = {{LW{1'b0}}, w_compacted} << (r_fill * SAMPLE_W);

  // Lanes below fill keep the staged partial word, the rest take new samples
  always_comb begin
    w_merged = w_shift;
    for (int j = 0; j < LANES; j++) begin
      if (j < int'(r_fill)) w_merged[j*SAMPLE_W +: SAMPLE_W] = r_stage[j*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Stage 0: staging lanes and partial-word timestamp (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_stage <= w_complete ? (w_merged >> LW) : w_merged;
      if (r_fill == '0 || w_spill) r_ts_part <= timestamp_in;
    end
  end

  // Stage 1: fill/mask control, output register and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask_q    <= chan_mask;
      r_fill      <= '0;
      r_sync_pend <= 1'b1;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_ts        <= '0;
      r_sync      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_valid && data_out_ready) r_valid <= 1'b0;
      if (w_mask_chg) begin
        r_mask_q    <= chan_mask;
        r_fill      <= '0;
        r_sync_pend <= 1'b1;
      end else if (w_accept) begin
        r_fill <= w_complete ? FILL_W'(w_sum - (FILL_W+1)'(LANES)) : w_sum[FILL_W-1:0];
        if (w_complete) begin
          if (w_out_free) begin
            r_valid     <= 1'b1;
            r_data      <= w_merged[LW-1:0];
            r_ts        <= w_word_ts;
            r_sync      <= r_sync_pend;
            r_sync_pend <= 1'b0;
          end else begin
            r_ovf       <= 1'b1;
            r_sync_pend <= 1'b1;
          end
        end
      end
    end
  end

  assign data_out_valid = r_valid;
  assign data_out       = r_data;
  assign data_out_sync  = r_sync;
  assign timestamp_out  = r_ts;
  assign overflow       = r_ovf;

endmodule
